// File: rtl/baud_tick_gen_if.sv
// Control/status bundle for baud_tick_gen.
// master: the block that owns rate selection and consumes the ticks.
// slave:  the baud_tick_gen itself.
interface baud_tick_gen_if #(
   parameter int DIV_W = 16
);
   logic             i_enable;
   logic [2:0]       i_baud_sel;
   logic [DIV_W-1:0] i_div_in;
   logic [3:0]       i_frac_in;
   logic             i_sync_clear;
   logic             o_rx_tick;
   logic             o_tx_tick;
   logic             o_baud_out;

   modport master (
      output i_enable, i_baud_sel, i_div_in, i_frac_in, i_sync_clear,
      input  o_rx_tick, o_tx_tick, o_baud_out
   );

   modport slave (
      input  i_enable, i_baud_sel, i_div_in, i_frac_in, i_sync_clear,
      output o_rx_tick, o_tx_tick, o_baud_out
   );
endinterface

// File: rtl/baud_tick_gen.sv
// UART baud-rate generator: oversample tick (rx), bit tick (tx) and a 50 %
// duty square wave, all from one divisor chain.
// Optional fractional divisor: define BAUD_TICK_FRAC_EN to build the
// 4-bit phase accumulator that stretches selected periods by one cycle.
module baud_tick_gen #(
   parameter int CLK_HZ = 50000000,
   parameter int OSR    = 16,
   parameter int DIV_W  = 16
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   baud_tick_gen_if.slave bus
);

   localparam int PH_W = $clog2(OSR);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(OSR / 2 - 1);

   // Round-half-up oversample divisor for a standard rate.
   function automatic logic [DIV_W-1:0] std_div(input longint baud);
      longint den;
      den = baud * longint'(OSR);
      return DIV_W'((longint'(CLK_HZ) + den / 2) / den);
   endfunction

   localparam logic [DIV_W-1:0] D_2400   = std_div(2400);
   localparam logic [DIV_W-1:0] D_4800   = std_div(4800);
   localparam logic [DIV_W-1:0] D_9600   = std_div(9600);
   localparam logic [DIV_W-1:0] D_19200  = std_div(19200);
   localparam logic [DIV_W-1:0] D_38400  = std_div(38400);
   localparam logic [DIV_W-1:0] D_57600  = std_div(57600);
   localparam logic [DIV_W-1:0] D_115200 = std_div(115200);

   logic [DIV_W-1:0] w_d_sel;       // divisor requested by baud_sel/div_in
   logic [DIV_W-1:0] w_period_end;  // cnt value on which the period ends
   logic             w_wrap;

   logic [DIV_W-1:0] r_d_act;
   logic [DIV_W-1:0] r_cnt;
   logic [PH_W-1:0]  r_ph;
   logic             r_init;        // low only until the first edge after reset
   logic             r_rx_tick;
   logic             r_tx_tick;
   logic             r_baud_out;

   // Decode the requested divisor; custom values below 2 clamp to 2.
   always_comb begin
      // NOTE: default assignment first so no path through the case leaves w_d_sel unassigned (no latch).
      w_d_sel = D_115200;
      case (bus.i_baud_sel)
         3'b000:  w_d_sel = D_2400;
         3'b001:  w_d_sel = D_4800;
         3'b010:  w_d_sel = D_9600;
         3'b011:  w_d_sel = D_19200;
         3'b100:  w_d_sel = D_38400;
         3'b101:  w_d_sel = D_57600;
         3'b110:  w_d_sel = D_115200;
         default: w_d_sel = (bus.i_div_in < DIV_W'(2)) ? DIV_W'(2) : bus.i_div_in;
      endcase
   end

`ifdef BAUD_TICK_FRAC_EN
   // Sixteenths remainder of the rounded 16x divisor for a standard rate.
   function automatic logic [3:0] std_frac(input longint baud);
      longint den;
      den = baud * longint'(OSR);
      return 4'(((16 * longint'(CLK_HZ) + den / 2) / den) % 16);
   endfunction

   localparam logic [3:0] F_2400   = std_frac(2400);
   localparam logic [3:0] F_4800   = std_frac(4800);
   localparam logic [3:0] F_9600   = std_frac(9600);
   localparam logic [3:0] F_19200  = std_frac(19200);
   localparam logic [3:0] F_38400  = std_frac(38400);
   localparam logic [3:0] F_57600  = std_frac(57600);
   localparam logic [3:0] F_115200 = std_frac(115200);

   logic [3:0] w_f_sel;
   logic [4:0] w_acc_sum;
   logic [3:0] r_acc;
   logic       r_stretch;           // current period lasts D+1 cycles

   // Decode the fractional increment matching the selected divisor.
   always_comb begin
      w_f_sel = F_115200;
      case (bus.i_baud_sel)
         3'b000:  w_f_sel = F_2400;
         3'b001:  w_f_sel = F_4800;
         3'b010:  w_f_sel = F_9600;
         3'b011:  w_f_sel = F_19200;
         3'b100:  w_f_sel = F_38400;
         3'b101:  w_f_sel = F_57600;
         3'b110:  w_f_sel = F_115200;
         default: w_f_sel = bus.i_frac_in;
      endcase
   end

   assign w_acc_sum    = {1'b0, r_acc} + {1'b0, w_f_sel};
   assign w_period_end = r_stretch ? r_d_act : r_d_act - DIV_W'(1);
`else
   logic w_frac_unused;
   assign w_frac_unused = &{1'b0, bus.i_frac_in};
   assign w_period_end  = r_d_act - DIV_W'(1);
`endif

   assign w_wrap = (r_cnt == w_period_end);

   // Divisor chain: oversample counter, phase counter and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_d_act    <= D_115200;
         r_cnt      <= '0;
         r_ph       <= '0;
         r_init     <= 1'b0;
         r_rx_tick  <= 1'b0;
         r_tx_tick  <= 1'b0;
         r_baud_out <= 1'b0;
`ifdef BAUD_TICK_FRAC_EN
         r_acc      <= '0;
         r_stretch  <= 1'b0;
`endif
      end else begin
         r_init <= 1'b1;
         if (bus.i_sync_clear) begin
            r_d_act    <= w_d_sel;
            r_cnt      <= '0;
            r_ph       <= '0;
            r_rx_tick  <= 1'b0;
            r_tx_tick  <= 1'b0;
            r_baud_out <= 1'b0;
`ifdef BAUD_TICK_FRAC_EN
            r_acc      <= '0;
            r_stretch  <= 1'b0;
`endif
         end else if (!bus.i_enable) begin
            // Counters and baud_out hold; the divisor tracks the selection.
            r_d_act   <= w_d_sel;
            r_rx_tick <= 1'b0;
            r_tx_tick <= 1'b0;
         end else if (w_wrap) begin
            r_d_act   <= w_d_sel;
            r_cnt     <= '0;
            r_rx_tick <= 1'b1;
            r_tx_tick <= (r_ph == PH_LAST);
            r_ph      <= (r_ph == PH_LAST) ? '0 : r_ph + PH_W'(1);
            if (r_ph == PH_LAST || r_ph == PH_HALF)
               r_baud_out <= ~r_baud_out;
`ifdef BAUD_TICK_FRAC_EN
            r_acc     <= w_acc_sum[3:0];
            r_stretch <= w_acc_sum[4];
`endif
         end else begin
            r_cnt     <= r_cnt + DIV_W'(1);
            r_rx_tick <= 1'b0;
            r_tx_tick <= 1'b0;
            // First edge after reset picks up the external selection.
            if (!r_init)
               r_d_act <= w_d_sel;
         end
      end
   end

   assign bus.o_rx_tick  = r_rx_tick;
   assign bus.o_tx_tick  = r_tx_tick;
   assign bus.o_baud_out = r_baud_out;

endmodule
